// File: rtl/fa_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
// State encoding, default width and counter width function.
package fa_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_serial_ctrl.sv
// Bit-serial operand sequencer for the registered full-adder stage.
// Optional FA_SERIAL_CHECK_EN adds a sticky fa_err sum-bit checker.
module fa_serial_ctrl
    import fa_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef FA_SERIAL_CHECK_EN
    output logic             cout,
    output logic             fa_err
`else
    output logic             cout
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             ci_q;
    logic [CW-1:0]    cnt;
    logic             maj;
    logic             last;
    logic [WIDTH:0]   sum_in;

    assign fa_a  = a_sh[0];
    assign fa_b  = b_sh[0];
    assign fa_ci = ci_q;

    assign maj  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);
    assign last = (cnt == CW'(WIDTH - 1));

    // Bit 0 of sum_sh is a spare slot so WIDTH=1 needs no special slice.
    assign sum_in = {fa_s, sum_sh};

    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            ci_q      <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= op_a;
                        b_sh     <= op_b;
                        carry    <= cin;
                        ci_q     <= cin;
                        cnt      <= '0;
                        sum_sh   <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry <= maj;
                    // Operands zero-fill, so fa_a/fa_b are 0 in DRAIN.
                    ci_q  <= last ? 1'b0 : maj;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt != '0)
                        sum_sh <= sum_in[WIDTH:1];
                    if (last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    sum       <= sum_in[WIDTH:1];
                    cout      <= carry;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef FA_SERIAL_CHECK_EN
    logic exp_q;
    logic cap;

    assign cap = ((state == SHIFT) && (cnt != '0)) ||
                 (state == DRAIN);

    always_ff @(posedge ck) begin
        if (rst) begin
            exp_q  <= 1'b0;
            fa_err <= 1'b0;
        end else begin
            exp_q <= fa_a ^ fa_b ^ fa_ci;
            if (cap && (fa_s != exp_q))
                fa_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Scoreboard bench for fa_serial_ctrl with a registered full-adder model.
// Define FA_SERIAL_CHECK_EN to also exercise fa_err.
module tb_fa_serial_ctrl;

    localparam int W = 8;

    logic         ck = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         fa_a;
    logic         fa_b;
    logic         fa_ci;
    logic         fa_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         s_q;
    logic         inj;
`ifdef FA_SERIAL_CHECK_EN
    logic         fa_err;
`endif

    int total = 0;
    int bad   = 0;
    logic [W:0] sb[$];

    always #5 ck = ~ck;

    // Registered full adder stage: sum only, same clock and reset.
    always_ff @(posedge ck) begin
        if (rst) s_q <= 1'b0;
        else     s_q <= fa_a ^ fa_b ^ fa_ci;
    end
    assign fa_s = s_q ^ inj;

    fa_serial_ctrl #(.WIDTH(W)) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_ci     (fa_ci),
        .fa_s      (fa_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef FA_SERIAL_CHECK_EN
        .cout      (cout),
        .fa_err    (fa_err)
`else
        .cout      (cout)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    function automatic logic [W-1:0] ci_model(
        input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W-1:0] s;
        logic         k;
        k = c;
        s = '0;
        for (int i = 0; i < W; i++) begin
            s[i] = k;
            k = (a[i] & b[i]) | (a[i] & k) | (b[i] & k);
        end
        return s;
    endfunction

    task automatic do_op(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic c,
                         input int hold,
                         output logic [W-1:0] fseq,
                         output logic [W-1:0] cseq);
        int           cyc;
        logic [W-1:0] s0;
        logic         c0;
        logic [W:0]   e;
        chk("rdy_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin  = c;
        tick();
        in_valid = 1'b0;
        sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
        cyc = 0;
        for (int k = 0; k < W; k++) begin
            fseq[k] = fa_a;
            cseq[k] = fa_ci;
            tick();
            cyc++;
        end
        chk("drain_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(W + 1));
        s0 = sum;
        c0 = cout;
        repeat (hold) tick();
        if (hold > 0) begin
            chk("bp_sum", 32'(sum), 32'(s0));
            chk("bp_cout", 32'(cout), 32'(c0));
            chk("bp_vld", 32'(out_valid), 32'd1);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sum", 32'(sum), 32'(e[W-1:0]));
            chk("cout", 32'(cout), 32'(e[W]));
        end
        tick();
        out_ready = 1'b0;
        chk("post_vld", 32'(out_valid), 32'd0);
        chk("post_rdy", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] fs;
        logic [W-1:0] cs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           n;
        rst = 1'b1;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        cin = 1'b0;
        out_ready = 1'b0;
        inj = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);

        do_op(8'h5A, 8'h3C, 1'b0, 1, fs, cs);
        chk("fa_a_seq", 32'(fs), 32'h5A);
        do_op(8'hFF, 8'h01, 1'b0, 1, fs, cs);
        chk("ci_seq1", 32'(cs), 32'hFE);
        do_op(8'hFF, 8'h00, 1'b1, 1, fs, cs);
        chk("ci_seq2", 32'(cs), 32'hFF);
        do_op(8'h80, 8'h80, 1'b1, 5, fs, cs);

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, i % 3, fs, cs);
            chk("rnd_fa", 32'(fs), 32'(ra));
            chk("rnd_ci", 32'(cs), 32'(ci_model(ra, rb, rc)));
        end

        // Abort mid-operation while bit 3 is on the adder inputs.
        in_valid = 1'b1;
        op_a = 8'h77;
        op_b = 8'h11;
        cin = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_fa_a", 32'(fa_a), 32'd0);
        chk("mid_ci", 32'(fa_ci), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_rdy", 32'(in_ready), 32'd1);
        chk("mr_vld", 32'(out_valid), 32'd0);
        chk("mr_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
        do_op(8'h01, 8'h01, 1'b0, 1, fs, cs);

`ifdef FA_SERIAL_CHECK_EN
        chk("err_clr", 32'(fa_err), 32'd0);
        in_valid = 1'b1;
        op_a = 8'h12;
        op_b = 8'h34;
        cin = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("err_set", 32'(fa_err), 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("err_done", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        do_op(8'h03, 8'h04, 1'b0, 1, fs, cs);
        chk("err_stk", 32'(fa_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_rst", 32'(fa_err), 32'd0);
`else
        n = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end

endmodule
